// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: drives the serial program memory address, captures
// completed words, and buffers {pc, instr} pairs for the decoder. A memory read
// starts only on an address change and cannot be aborted, so redirects that land
// mid-read are parked in pend_pc until the in-flight completion arrives.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_instr,
    input  logic        mem_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    output logic [15:0] out_pc,
    output logic [15:0] out_instr,
    input  logic        out_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_WAIT,        // read in flight for mem_addr_reg
        ST_FULL,        // memory idle, queue full, mem_addr_reg = last completed address
        ST_FLUSH_WAIT   // redirect pending behind an unabortable read
    } state_t;

    state_t        state_reg;
    logic [15:0]   mem_addr_reg;
    logic [15:0]   pend_pc_reg;
    logic [15:0]   last_word_reg;
    logic          last_valid_reg;
    logic [CW-1:0] count_reg;
    logic [15:0]   q_pc_reg    [DEPTH];
    logic [15:0]   q_instr_reg [DEPTH];

    logic          pop;
    logic [CW-1:0] pop_ext;
    logic [CW-1:0] wr_idx;
    logic [CW-1:0] cnt_push;
    logic [15:0]   target;
    logic          redirect_now;
    logic          replay;
    logic          normal_push;
    logic          q_push;
    logic          q_shift;
    logic [IW-1:0] push_slot;
    logic [15:0]   q_push_pc;
    logic [15:0]   q_push_instr;

    assign pop      = (count_reg != '0) && out_ready;
    assign pop_ext  = {{(CW-1){1'b0}}, pop};
    // Slot a push lands in once any same-cycle pop has shifted the queue down
    assign wr_idx   = count_reg - pop_ext;
    assign cnt_push = wr_idx + CW'(1);
    assign target   = redirect_pc & 16'hFFFE;

    // Redirects that can be acted on now: the memory is idle or completes this cycle
    assign redirect_now = redirect_valid && (mem_ready || state_reg == ST_FULL);
    // Target equals the address already presented: memory will not re-read, so
    // re-insert the word it last returned
    assign replay       = redirect_now && (target == mem_addr_reg) &&
                          (mem_ready || last_valid_reg);
    assign normal_push  = !redirect_valid && mem_ready &&
                          (state_reg == ST_WAIT ||
                           (state_reg == ST_FLUSH_WAIT && pend_pc_reg == mem_addr_reg));

    assign q_push       = replay || normal_push;
    assign q_shift      = pop && !redirect_valid;
    assign push_slot    = replay ? '0 : wr_idx[IW-1:0];
    assign q_push_pc    = replay ? target : mem_addr_reg;
    assign q_push_instr = (replay && !mem_ready) ? last_word_reg : mem_instr;

    assign mem_addr  = mem_addr_reg;
    assign out_valid = (count_reg != '0);
    assign out_pc    = q_pc_reg[0];
    assign out_instr = q_instr_reg[0];

    // Fetch control: address sequencing, occupancy, redirect handling
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_WAIT;
            mem_addr_reg   <= RESET_PC;
            pend_pc_reg    <= '0;
            last_word_reg  <= '0;
            last_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            if (mem_ready) begin
                last_word_reg  <= mem_instr;
                last_valid_reg <= 1'b1;
            end
            if (redirect_now) begin
                state_reg <= ST_WAIT;
                if (replay) begin
                    count_reg    <= CW'(1);
                    mem_addr_reg <= target + 16'd2;
                end else begin
                    count_reg    <= '0;
                    mem_addr_reg <= target;
                end
            end else if (redirect_valid) begin
                // Read still in flight: hold the address, remember the latest target
                count_reg   <= '0;
                pend_pc_reg <= target;
                state_reg   <= ST_FLUSH_WAIT;
            end else begin
                case (state_reg)
                    ST_WAIT: begin
                        if (mem_ready) begin
                            count_reg <= cnt_push;
                            if (cnt_push < CW'(DEPTH)) begin
                                mem_addr_reg <= mem_addr_reg + 16'd2;
                            end else begin
                                state_reg <= ST_FULL;
                            end
                        end else begin
                            count_reg <= count_reg - pop_ext;
                        end
                    end
                    ST_FULL: begin
                        count_reg <= count_reg - pop_ext;
                        if (pop) begin
                            mem_addr_reg <= mem_addr_reg + 16'd2;
                            state_reg    <= ST_WAIT;
                        end
                    end
                    ST_FLUSH_WAIT: begin
                        if (mem_ready) begin
                            state_reg <= ST_WAIT;
                            if (pend_pc_reg != mem_addr_reg) begin
                                mem_addr_reg <= pend_pc_reg;
                            end else begin
                                count_reg    <= CW'(1);
                                mem_addr_reg <= pend_pc_reg + 16'd2;
                            end
                        end
                    end
                    default: state_reg <= ST_WAIT;
                endcase
            end
        end
    end

    // Queue storage: entry 0 is the head; pops shift down, pushes land after the shift
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_reg[i]    <= '0;
                q_instr_reg[i] <= '0;
            end
        end else begin
            if (q_shift) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    q_pc_reg[i]    <= q_pc_reg[i+1];
                    q_instr_reg[i] <= q_instr_reg[i+1];
                end
            end
            if (q_push) begin
                q_pc_reg[push_slot]    <= q_push_pc;
                q_instr_reg[push_slot] <= q_push_instr;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a serial program memory model (address-change
// triggered, unabortable reads) plus a stream model: after reset the decoder
// must see RESET_PC, +2, +4 ...; after each redirect it must see T, T+2, ...
module tb_instr_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'hFFFC;
    localparam logic [15:0] KEY    = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic [15:0] mem_instr = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // memory model
    bit          m_busy = 1'b0;
    bit          m_need_start = 1'b1;
    logic [15:0] m_rd_addr = 16'h0000;
    logic [15:0] m_last_addr = 16'h0000;
    int          m_remain = 0;
    int          lat_fixed = 0;
    bit          lat_rand = 1'b0;

    // decoder-visible stream model
    logic [15:0] exp_pc = RST_PC;
    int          pops = 0;
    logic [15:0] pop_log[$];
    int          gap = 0;
    int          max_gap = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample pre-edge, step, update stream and memory models
    task automatic cycle();
        logic        pop_now, redir_now, rst_now, ready_now;
        logic [15:0] pc_now, instr_now, tgt_now;
        pop_now   = out_valid && out_ready;
        redir_now = redirect_valid;
        rst_now   = rst;
        ready_now = mem_ready;
        pc_now    = out_pc;
        instr_now = out_instr;
        tgt_now   = redirect_pc;
        @(posedge clk);
        #1;
        if (rst_now) begin
            exp_pc = RST_PC;
        end else if (redir_now) begin
            exp_pc = tgt_now & 16'hFFFE;
            gap = 0;
        end else if (pop_now === 1'b1) begin
            chk("pop_pc", pc_now, exp_pc);
            chk("pop_instr", instr_now, exp_pc ^ KEY);
            pop_log.push_back(pc_now);
            pops++;
            exp_pc = exp_pc + 16'd2;
            gap = 0;
        end else begin
            gap++;
        end
        if (gap > max_gap) max_gap = gap;

        if (rst_now) begin
            m_busy = 1'b0;
            m_need_start = 1'b1;
        end else begin
            if (m_busy && !ready_now) begin
                chk("mem_addr_hold", mem_addr, m_rd_addr);
                if (m_remain > 0) m_remain--;
            end
            if (ready_now) begin
                m_busy = 1'b0;
                m_last_addr = m_rd_addr;
            end
            if (!m_busy && (m_need_start || mem_addr !== m_last_addr)) begin
                m_busy = 1'b1;
                m_need_start = 1'b0;
                m_rd_addr = mem_addr;
                m_remain = lat_rand ? int'($urandom_range(3, 0)) : lat_fixed;
            end
        end
        mem_ready = m_busy && (m_remain == 0);
        mem_instr = mem_ready ? (m_rd_addr ^ KEY) : 16'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        cycle();
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_mem_addr", mem_addr, RST_PC);
        chk("rst_out_pc", out_pc, 16'h0000);
        chk("rst_out_instr", out_instr, 16'h0000);
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_pop(input string tag, input logic [15:0] first_pc);
        int start;
        bit got;
        start = pops;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (pops != start) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL %s_timeout observed=no_pop expected=pop", tag);
        end
        if (got) chk(tag, pop_log[pop_log.size()-1], first_pc);
    endtask

    initial begin
        int  base;
        bit  seen;
        logic rdy;

        // Sequential fill with wrap from FFFC, single-cycle memory
        lat_fixed = 0;
        out_ready = 1'b1;
        do_reset();
        pop_log.delete();
        base = pops;
        run(20);
        chk("fill_pop_count", 16'(pops - base), 16'd18);
        chk("fill_pc0", pop_log[0], 16'hFFFC);
        chk("fill_pc1", pop_log[1], 16'hFFFE);
        chk("fill_pc2", pop_log[2], 16'h0000);

        // Full stall: four entries FFFC..0002, address held at 0002
        out_ready = 1'b0;
        lat_fixed = 1;
        do_reset();
        run(30);
        chk("stall_addr", mem_addr, 16'h0002);
        chk("stall_valid", {15'd0, out_valid}, 16'd1);
        chk("stall_head", out_pc, 16'hFFFC);
        run(3);
        chk("stall_addr_held", mem_addr, 16'h0002);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("pop_adv_addr", mem_addr, 16'h0004);
        chk("pop_new_head", out_pc, 16'hFFFE);

        // Same-address replay: full at 0004, redirect to 0005 (bit 0 dropped)
        run(20);
        chk("refill_addr", mem_addr, 16'h0004);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0005;
        cycle();
        redirect_valid = 1'b0;
        chk("replay_valid", {15'd0, out_valid}, 16'd1);
        chk("replay_pc", out_pc, 16'h0004);
        chk("replay_instr", out_instr, 16'h0004 ^ KEY);
        chk("replay_addr", mem_addr, 16'h0006);

        // Idle redirect from a full queue
        run(20);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        cycle();
        redirect_valid = 1'b0;
        chk("idle_redir_addr", mem_addr, 16'h0040);
        chk("idle_redir_cleared", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b1;
        wait_pop("idle_redir_first", 16'h0040);

        // Redirects during an in-flight read of 0004
        out_ready = 1'b0;
        lat_fixed = 3;
        run(40);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0004;
        cycle();
        chk("inflight_start", mem_addr, 16'h0004);
        redirect_pc = 16'h0100;
        cycle();
        chk("inflight_hold", mem_addr, 16'h0004);
        redirect_pc = 16'h0200;
        cycle();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rdy = mem_ready;
            cycle();
            if (rdy) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL inflight_completion observed=none expected=mem_ready");
        end
        chk("inflight_new_addr", mem_addr, 16'h0200);
        chk("inflight_no_stale", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b1;
        wait_pop("inflight_first", 16'h0200);

        // Reset in the middle of a read
        run(2);
        rst = 1'b1;
        cycle();
        chk("rst_mid_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_mid_addr", mem_addr, RST_PC);
        rst = 1'b0;
        wait_pop("rst_mid_first", RST_PC);

        // Randomised traffic against the stream model
        lat_rand = 1'b1;
        gap = 0;
        max_gap = 0;
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            case ($urandom_range(3, 0))
                0: redirect_pc = mem_addr | 16'($urandom_range(1, 0));
                1: redirect_pc = mem_addr + 16'd2;
                default: redirect_pc = 16'($urandom);
            endcase
            cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        assert (max_gap <= 40) else begin
            failures++;
            $error("FAIL rand_progress observed=%0d expected<=40", max_gap);
        end
        out_ready = 1'b1;
        wait_pop("drain_first", exp_pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
